// File: rtl/ship_pkg.sv
// ship_pkg: shared types and defaults for the ship sprite read path.
// Provides anim_state_t (3-bit animation state), frame_sel_t (ROM frame select),
// sprite size / attack length defaults and the movement-rule helper.
package ship_pkg;
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MOVE_LEFT  = 3'd1,
    ST_MOVE_RIGHT = 3'd2,
    ST_ATTACK     = 3'd3,
    ST_DEAD       = 3'd4
  } anim_state_t;
  // The frame chosen from the ROM is exactly the animation state.
  typedef anim_state_t frame_sel_t;
  localparam int DEF_SPRITE_W      = 80;
  localparam int DEF_SPRITE_H      = 80;
  localparam int DEF_ATTACK_FRAMES = 12;
  function automatic anim_state_t move_state(input logic left, input logic right);
    return (left && !right) ? ST_MOVE_LEFT : (right && !left) ? ST_MOVE_RIGHT : ST_IDLE;
  endfunction
endpackage

// File: rtl/ship_anim_fsm.sv
// ship_anim_fsm: ship animation state machine, advanced only on frame strobes.
// Ports: Clk, Reset (async, active-high), frame_clk_rise (update strobe),
// move_left/move_right/attack_req/hit (levels sampled on strobe),
// anim_state (current state), attack_busy (high in ATTACK).
module ship_anim_fsm
  import ship_pkg::*;
#(
  parameter int ATTACK_FRAMES = DEF_ATTACK_FRAMES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk_rise,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        attack_req,
  input  logic        hit,
  output anim_state_t anim_state,
  output logic        attack_busy
);
  localparam int CW = (ATTACK_FRAMES > 1) ? $clog2(ATTACK_FRAMES) : 1;
  anim_state_t st_n;
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      anim_state <= ST_IDLE;
      cnt        <= '0;
    end else begin
      anim_state <= st_n;
      cnt        <= cnt_n;
    end
  end
  // hit dominates; DEAD only leaves via Reset; ATTACK cannot be retriggered.
  always_comb begin
    st_n  = anim_state;
    cnt_n = cnt;
    if (frame_clk_rise) begin
      if (hit)
        st_n = ST_DEAD;
      else if (anim_state == ST_ATTACK) begin
        if (cnt == '0)
          st_n = move_state(move_left, move_right);
        else
          cnt_n = cnt - 1'b1;
      end else if (anim_state != ST_DEAD) begin
        if (attack_req) begin
          st_n  = ST_ATTACK;
          cnt_n = CW'(ATTACK_FRAMES - 1);
        end else
          st_n = move_state(move_left, move_right);
      end
    end
  end
  assign attack_busy = anim_state == ST_ATTACK;
endmodule

// File: rtl/ship_sprite_fetch.sv
// ship_sprite_fetch: scan position -> sprite ROM address, frame select and palette index.
// Ports: Clk, Reset (async, active-high), frame_clk_rise, DrawX/DrawY (scan pixel),
// ShipX/ShipY (sprite top-left), move_left/move_right/attack_req/hit (animation inputs),
// read_address (ROM address), data_11..data_15 (ROM frames idle/left/right/attack/dead),
// pixel_on/pixel_index (3-cycle latency), anim_state, attack_busy.
module ship_sprite_fetch
  import ship_pkg::*;
#(
  parameter int SPRITE_W      = DEF_SPRITE_W,
  parameter int SPRITE_H      = DEF_SPRITE_H,
  parameter int ATTACK_FRAMES = DEF_ATTACK_FRAMES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk_rise,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  ShipX,
  input  logic [9:0]  ShipY,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        attack_req,
  input  logic        hit,
  output logic [18:0] read_address,
  input  logic [3:0]  data_11,
  input  logic [3:0]  data_12,
  input  logic [3:0]  data_13,
  input  logic [3:0]  data_14,
  input  logic [3:0]  data_15,
  output logic        pixel_on,
  output logic [3:0]  pixel_index,
  output logic [2:0]  anim_state,
  output logic        attack_busy
);
  anim_state_t state;
  frame_sel_t sel_d1, sel_d2;
  logic in_box, in_box_d1, in_box_d2;
  logic [10:0] dx, dy, sx, sy;
  logic [12:0] rx, ry, addr;
  logic [3:0] rom_pix;
  ship_anim_fsm #(.ATTACK_FRAMES(ATTACK_FRAMES)) u_fsm (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_clk_rise (frame_clk_rise),
    .move_left      (move_left),
    .move_right     (move_right),
    .attack_req     (attack_req),
    .hit            (hit),
    .anim_state     (state),
    .attack_busy    (attack_busy)
  );
  assign anim_state = state;
  // 11-bit compare so a sprite hanging off the right/bottom edge never wraps.
  assign dx = {1'b0, DrawX};
  assign dy = {1'b0, DrawY};
  assign sx = {1'b0, ShipX};
  assign sy = {1'b0, ShipY};
  assign in_box = dx >= sx && dx < sx + 11'(SPRITE_W) && dy >= sy && dy < sy + 11'(SPRITE_H);
  assign rx = 13'(dx - sx);
  assign ry = 13'(dy - sy);
  assign addr = !in_box ? '0 :
                (SPRITE_W == 80) ? (ry << 6) + (ry << 4) + rx : ry * 13'(SPRITE_W) + rx;
  always_comb
    rom_pix = (sel_d2 == ST_IDLE)       ? data_11 :
              (sel_d2 == ST_MOVE_LEFT)  ? data_12 :
              (sel_d2 == ST_MOVE_RIGHT) ? data_13 :
              (sel_d2 == ST_ATTACK)     ? data_14 : data_15;
  // The frame select rides with the address so a mid-line state change never mixes frames.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      read_address <= '0;
      in_box_d1    <= 1'b0;
      in_box_d2    <= 1'b0;
      sel_d1       <= ST_IDLE;
      sel_d2       <= ST_IDLE;
      pixel_on     <= 1'b0;
      pixel_index  <= '0;
    end else begin
      read_address <= {6'd0, addr};
      in_box_d1    <= in_box;
      sel_d1       <= state;
      in_box_d2    <= in_box_d1;
      sel_d2       <= sel_d1;
      pixel_on     <= in_box_d2 && rom_pix != 4'd0;
      pixel_index  <= in_box_d2 ? rom_pix : 4'd0;
    end
  end
endmodule

// File: tb/tb_ship_sprite_fetch.sv
// tb_ship_sprite_fetch: directed and randomized checks against a behavioural ship model.
module tb_ship_sprite_fetch;
  logic Clk = 1'b0, Reset = 1'b1, frame_clk_rise = 1'b0;
  logic move_left = 1'b0, move_right = 1'b0, attack_req = 1'b0, hit = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, ShipX = '0, ShipY = '0;
  logic [3:0] data_11 = '0, data_12 = '0, data_13 = '0, data_14 = '0, data_15 = '0;
  logic [18:0] read_address;
  logic pixel_on, attack_busy;
  logic [3:0] pixel_index;
  logic [2:0] anim_state;
  int n_cmp = 0, n_bad = 0;
  int ea[0:19999];
  int ep[0:19999];
  int ms = 0, left = 0, cyc = 0, base = 0;
  ship_sprite_fetch dut (
    .Clk(Clk), .Reset(Reset), .frame_clk_rise(frame_clk_rise),
    .DrawX(DrawX), .DrawY(DrawY), .ShipX(ShipX), .ShipY(ShipY),
    .move_left(move_left), .move_right(move_right), .attack_req(attack_req), .hit(hit),
    .read_address(read_address),
    .data_11(data_11), .data_12(data_12), .data_13(data_13), .data_14(data_14), .data_15(data_15),
    .pixel_on(pixel_on), .pixel_index(pixel_index), .anim_state(anim_state), .attack_busy(attack_busy)
  );
  always #5 Clk = ~Clk;
  function automatic logic [3:0] rom(int f, int a);
    return 4'((a * 13 + f * 5 + 5 + (a >> 4)) % 16);
  endfunction
  // Synchronous five-frame ROM: data valid one clock after the address.
  always @(posedge Clk) begin
    data_11 <= rom(0, int'(read_address));
    data_12 <= rom(1, int'(read_address));
    data_13 <= rom(2, int'(read_address));
    data_14 <= rom(3, int'(read_address));
    data_15 <= rom(4, int'(read_address));
  end
  task automatic check(string tag, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", tag, cyc, act, exp);
    end
  endtask
  function automatic int mv();
    return (move_left && !move_right) ? 1 : (move_right && !move_left) ? 2 : 0;
  endfunction
  // One clock: predict what this edge does, then check everything after it.
  task automatic step();
    int dx, dy, sx, sy, a, e;
    bit box;
    dx = int'(DrawX); dy = int'(DrawY); sx = int'(ShipX); sy = int'(ShipY);
    box = dx >= sx && dx < sx + 80 && dy >= sy && dy < sy + 80;
    a = box ? (dy - sy) * 80 + (dx - sx) : 0;
    ea[cyc] = a;
    ep[cyc] = box ? int'(rom(ms, a)) : 0;
    if (frame_clk_rise) begin
      if (hit) ms = 4;
      else if (ms == 3) begin
        left--;
        if (left == 0) ms = mv();
      end else if (ms != 4) begin
        if (attack_req) begin ms = 3; left = 12; end
        else ms = mv();
      end
    end
    @(negedge Clk);
    check("read_address", int'(read_address), ea[cyc]);
    check("anim_state", int'(anim_state), ms);
    check("attack_busy", int'(attack_busy), int'(ms == 3));
    e = (cyc - 2 >= base) ? ep[cyc - 2] : 0;
    check("pixel_index", int'(pixel_index), e);
    check("pixel_on", int'(pixel_on), int'(e != 0));
    cyc++;
  endtask
  task automatic do_reset();
    Reset = 1'b1;
    #1;
    check("rst_addr", int'(read_address), 0);
    check("rst_on", int'(pixel_on), 0);
    check("rst_idx", int'(pixel_index), 0);
    check("rst_state", int'(anim_state), 0);
    check("rst_busy", int'(attack_busy), 0);
    @(negedge Clk);
    Reset = 1'b0;
    ms = 0; left = 0; base = cyc;
  endtask
  task automatic strobe_steps(int n);
    frame_clk_rise = 1'b1;
    step();
    frame_clk_rise = 1'b0;
    attack_req = 1'b0;
    hit = 1'b0;
    repeat (n) begin
      DrawX = DrawX + 10'd1;
      step();
    end
  endtask
  initial begin
    @(negedge Clk);
    do_reset();
    ShipX = 10'd100; ShipY = 10'd50;
    DrawX = 10'd100; DrawY = 10'd50; step();
    DrawX = 10'd179; DrawY = 10'd129; step();
    DrawX = 10'd180; step();
    DrawX = 10'd107; DrawY = 10'd50; step();
    DrawX = 10'd99; step();
    ShipX = 10'd600; DrawX = 10'd639; DrawY = 10'd60; step();
    ShipX = 10'd1000; ShipY = 10'd990; DrawX = 10'd1023; DrawY = 10'd1023; step();
    DrawX = 10'd5; DrawY = 10'd5; step();
    repeat (3) step();
    ShipX = 10'd100; ShipY = 10'd50; DrawX = 10'd110; DrawY = 10'd70;
    attack_req = 1'b1; strobe_steps(3);
    move_right = 1'b1;
    for (int i = 0; i < 13; i++) begin
      attack_req = (i == 5);
      strobe_steps(2);
    end
    move_right = 1'b0;
    attack_req = 1'b1; strobe_steps(2);
    strobe_steps(2);
    hit = 1'b1; strobe_steps(3);
    move_left = 1'b1; strobe_steps(2);
    attack_req = 1'b1; strobe_steps(4);
    move_left = 1'b0;
    do_reset();
    repeat (3) step();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        ShipX = 10'($urandom_range(0, 1023));
        ShipY = 10'($urandom_range(0, 1023));
      end
      DrawX = 10'(int'(ShipX) + int'($urandom_range(0, 99)) - 10);
      DrawY = 10'(int'(ShipY) + int'($urandom_range(0, 99)) - 10);
      frame_clk_rise = $urandom_range(0, 3) == 0;
      move_left = $urandom_range(0, 1) == 1;
      move_right = $urandom_range(0, 1) == 1;
      attack_req = $urandom_range(0, 5) == 0;
      hit = $urandom_range(0, 300) == 0;
      step();
      if ($urandom_range(0, 500) == 0) do_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ship_sprite_fetch.md
# ship_sprite_fetch

Read-side consumer for the five-frame ship sprite ROM: converts the VGA scan position and the ship's on-screen position into ROM read addresses, selects one of the five animation frames from an internal animation state machine, and returns a registered, transparency-resolved 4-bit palette index to the colour mapper. One instance sits between the VGA controller/ship motion logic and each read port of the sprite ROM (player 1 and player 2 each get one).

## Interface
- SPRITE_W, 80, sprite width in pixels
- SPRITE_H, 80, sprite height in pixels
- ATTACK_FRAMES, 12, video frames the ATTACK animation is held
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_clk_rise  in  1  one-cycle pulse at start of each video frame; sole update strobe for the animation FSM
- DrawX, DrawY  in  10  current scan pixel
- ShipX, ShipY  in  10  sprite top-left corner on screen
- move_left, move_right, attack_req, hit  in  1  level inputs, sampled only on frame_clk_rise
- read_address  out  19  address to ROM read port
- data_11, data_12, data_13, data_14, data_15  in  4 each  ROM outputs: idle, move_left, move, attack, dead frames; valid one Clk after read_address
- pixel_on  out  1  sprite covers pixel and index is non-transparent
- pixel_index  out  4  palette index; 0 when pixel_on = 0
- anim_state  out  3  current animation state (encoding below)
- attack_busy  out  1  high while in ATTACK

## Operation
- Animation states: IDLE=0, MOVE_LEFT=1, MOVE_RIGHT=2, ATTACK=3, DEAD=4. The FSM changes only on cycles with frame_clk_rise=1.
- Transition priority on each strobe: hit=1 → DEAD from any state; DEAD is sticky until Reset. Else if state≠ATTACK and attack_req=1 → ATTACK, load attack counter with ATTACK_FRAMES-1. In ATTACK: counter decrements per strobe; on strobe with counter=0, leave ATTACK using the movement rule. attack_req is ignored during ATTACK (no retrigger). Movement rule: move_left only → MOVE_LEFT; move_right only → MOVE_RIGHT; both or neither → IDLE.
- Frame select: IDLE→data_11, MOVE_LEFT→data_12, MOVE_RIGHT→data_13, ATTACK→data_14, DEAD→data_15.
- Box test in 11-bit unsigned arithmetic: in_box = DrawX≥ShipX and DrawX<ShipX+SPRITE_W and DrawY≥ShipY and DrawY<ShipY+SPRITE_H. Sprite partly off the right/bottom edge is legal; no wrap.
- Address = (DrawY-ShipY)*SPRITE_W + (DrawX-ShipX) when in_box, else 0; max 6399, computed in 13 bits, zero-extended to 19. For SPRITE_W=80 use (ry<<6)+(ry<<4); no multiplier.
- Transparency: selected index 0 → pixel_on=0, pixel_index=0.

## Timing
- Stage 1 (posedge after DrawX/DrawY valid): read_address, in_box_d1, frame select sel_d1 registered.
- Stage 2: ROM returns data; in_box_d2, sel_d2 registered alongside.
- Stage 3: pixel_on/pixel_index registered from sel_d2 mux and in_box_d2.
- Latency DrawX/DrawY → pixel_on/pixel_index = 3 Clk; the colour mapper delays DrawX/DrawY by 3 to match.
- anim_state, attack_busy update the Clk after the strobe edge; frame select carried through the pipeline, so a state change never mixes frames within one pixel.
- Reset (any time, including mid-line or mid-ATTACK): read_address=0, pixel_on=0, pixel_index=0, anim_state=IDLE, attack_busy=0, attack counter=0, all pipeline valids cleared.

## Structure
- Shared package ship_pkg: anim_state_t enum (3-bit, encodings above), SPRITE_W/SPRITE_H defaults, frame-select type.
- Sub-module ship_anim_fsm: state register, attack counter, priority logic; outputs anim_state and attack_busy. Address pipeline and mux stay in the top.

## Test plan
- Ship at (100,50), state IDLE, ROM model index 5 at address 0: DrawX=100, DrawY=50 → read_address=0 after 1 Clk, pixel_on=1, pixel_index=5 after 3 Clk.
- DrawX=179, DrawY=129 with ship (100,50) → read_address=6399; DrawX=180 → read_address=0, pixel_on=0 at +3.
- ROM index 0 at in-box address → pixel_on=0, pixel_index=0.
- attack_req pulse with strobe → anim_state=3, attack_busy=1 for exactly 12 strobes; attack_req reasserted mid-attack ignored; move_right held → MOVE_RIGHT after.
- hit during ATTACK → DEAD next strobe; later move/attack ignored; data_15 selected; Reset → IDLE, outputs 0.
- ShipX=600 (sprite off right edge), DrawX=639 → in_box, address = rel_y*80+39; no wrap.
